// File: rtl/matrix_pkg.sv
// Shared matrix-extension definitions: operation enum, instruction encodings
// (mask/match pairs) and the dispatch entry carried through the buffer.
package matrix_pkg;

  typedef enum logic [3:0] {
    OP_NONE     = 4'd0,
    OP_MLD_B    = 4'd1,
    OP_MLD_H    = 4'd2,
    OP_MLD_W    = 4'd3,
    OP_MST_B    = 4'd4,
    OP_MST_H    = 4'd5,
    OP_MST_W    = 4'd6,
    OP_FMMACC_S = 4'd7,
    OP_FMMACC_H = 4'd8,
    OP_FMMACC_D = 4'd9,
    OP_MMAQA_B  = 4'd10,
    OP_MMADA_H  = 4'd11,
    OP_MMASA_W  = 4'd12,
    OP_MZERO    = 4'd13
  } matrix_op_e;

  // Loads/stores live in custom-0: funct7 [31:25] and funct3 [14:12] are fixed,
  // everything else (tile index, register fields) is a don't-care for decode.
  localparam logic [31:0] LS_MASK     = 32'hFE00_707F;
  localparam logic [31:0] ENC_MLD_B   = 32'h0000_000B;
  localparam logic [31:0] ENC_MLD_H   = 32'h0000_100B;
  localparam logic [31:0] ENC_MLD_W   = 32'h0000_200B;
  localparam logic [31:0] ENC_MST_B   = 32'h0000_400B;
  localparam logic [31:0] ENC_MST_H   = 32'h0000_500B;
  localparam logic [31:0] ENC_MST_W   = 32'h0000_600B;

  // Arithmetic and MZERO live in custom-1: funct8 [31:24] selects the family,
  // funct3 [14:12] the element type; [23:15] carry ms2/ms1/md.
  localparam logic [31:0] AR_MASK     = 32'hFF00_707F;
  localparam logic [31:0] ENC_MZERO   = 32'h0000_002B;
  localparam logic [31:0] ENC_FMMACC_S = 32'h0100_002B;
  localparam logic [31:0] ENC_FMMACC_H = 32'h0100_102B;
  localparam logic [31:0] ENC_FMMACC_D = 32'h0100_202B;
  localparam logic [31:0] ENC_MMAQA_B = 32'h0200_002B;
  localparam logic [31:0] ENC_MMADA_H = 32'h0200_102B;
  localparam logic [31:0] ENC_MMASA_W = 32'h0200_202B;

  typedef struct packed {
    matrix_op_e  op;
    logic [2:0]  md;
    logic [2:0]  ms1;
    logic [2:0]  ms2;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } disp_entry_t;

  function automatic logic enc_hit(input logic [31:0] instr,
                                   input logic [31:0] mask,
                                   input logic [31:0] match);
    return (instr & mask) == match;
  endfunction

endpackage

// File: rtl/matrix_dispatch_fifo.sv
// Circular buffer of dispatch entries. Only pointers and occupancy are reset;
// storage is overwritten on push and never read while empty.
module matrix_dispatch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/matrix_dispatcher.sv
// Matrix instruction dispatcher: decodes offloaded instructions, answers each
// handshake with an accept/reject response one cycle later, and queues legal
// operations in order for the execution units.
// Build option: define MATRIX_INT_OPS_EN to accept the integer multiply-
// accumulate family (MMAQA_B, MMADA_H, MMASA_W); otherwise they are rejected.
module matrix_dispatcher
  import matrix_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [31:0]     rs1_i,
  input  logic [31:0]     rs2_i,
  input  logic [ID_W-1:0] id_i,
  output logic            resp_valid_o,
  output logic            resp_accept_o,
  output logic [ID_W-1:0] resp_id_o,
  output logic            disp_valid_o,
  input  logic            disp_ready_i,
  output matrix_op_e      disp_op_o,
  output logic [2:0]      disp_md_o,
  output logic [2:0]      disp_ms1_o,
  output logic [2:0]      disp_ms2_o,
  output logic [31:0]     disp_rs1_o,
  output logic [31:0]     disp_rs2_o,
  output logic [ID_W-1:0] disp_id_o
);

  typedef struct packed {
    disp_entry_t     body;
    logic [ID_W-1:0] id;
  } slot_t;

  matrix_op_e      dec_op;
  logic [2:0]      dec_md;
  logic [2:0]      dec_ms1;
  logic [2:0]      dec_ms2;
  logic            legal;
  logic            handshake;
  logic            full;
  logic            empty;
  slot_t           push_slot;
  slot_t           head_slot;
  logic            resp_vld_p1;
  logic            resp_acc_p1;
  logic [ID_W-1:0] resp_id_p1;

  // Input side: no bypass, so a full buffer stalls even if the head pops this cycle
  assign instr_ready_o = ~rst_i & ~full;
  assign handshake     = instr_valid_i & instr_ready_o;
  assign legal         = (dec_op != OP_NONE);

  // Opcode match against the package encodings
  always_comb begin
    dec_op = OP_NONE;
    if      (enc_hit(instr_i, LS_MASK, ENC_MLD_B))    dec_op = OP_MLD_B;
    else if (enc_hit(instr_i, LS_MASK, ENC_MLD_H))    dec_op = OP_MLD_H;
    else if (enc_hit(instr_i, LS_MASK, ENC_MLD_W))    dec_op = OP_MLD_W;
    else if (enc_hit(instr_i, LS_MASK, ENC_MST_B))    dec_op = OP_MST_B;
    else if (enc_hit(instr_i, LS_MASK, ENC_MST_H))    dec_op = OP_MST_H;
    else if (enc_hit(instr_i, LS_MASK, ENC_MST_W))    dec_op = OP_MST_W;
    else if (enc_hit(instr_i, AR_MASK, ENC_FMMACC_S)) dec_op = OP_FMMACC_S;
    else if (enc_hit(instr_i, AR_MASK, ENC_FMMACC_H)) dec_op = OP_FMMACC_H;
    else if (enc_hit(instr_i, AR_MASK, ENC_FMMACC_D)) dec_op = OP_FMMACC_D;
    else if (enc_hit(instr_i, AR_MASK, ENC_MZERO))    dec_op = OP_MZERO;
`ifdef MATRIX_INT_OPS_EN
    else if (enc_hit(instr_i, AR_MASK, ENC_MMAQA_B))  dec_op = OP_MMAQA_B;
    else if (enc_hit(instr_i, AR_MASK, ENC_MMADA_H))  dec_op = OP_MMADA_H;
    else if (enc_hit(instr_i, AR_MASK, ENC_MMASA_W))  dec_op = OP_MMASA_W;
`endif
  end

  // Tile index extraction by operation class; indices an op does not use stay 0
  always_comb begin
    dec_md  = '0;
    dec_ms1 = '0;
    dec_ms2 = '0;
    case (dec_op)
      OP_MLD_B, OP_MLD_H, OP_MLD_W,
      OP_MST_B, OP_MST_H, OP_MST_W: dec_md = instr_i[9:7];
      OP_FMMACC_S, OP_FMMACC_H, OP_FMMACC_D,
      OP_MMAQA_B, OP_MMADA_H, OP_MMASA_W: begin
        dec_ms2 = instr_i[23:21];
        dec_ms1 = instr_i[20:18];
        dec_md  = instr_i[17:15];
      end
      OP_MZERO: dec_md = instr_i[17:15];
      default: ;
    endcase
  end

  // Assemble the buffered entry
  always_comb begin
    push_slot          = '0;
    push_slot.body.op  = dec_op;
    push_slot.body.md  = dec_md;
    push_slot.body.ms1 = dec_ms1;
    push_slot.body.ms2 = dec_ms2;
    push_slot.body.rs1 = rs1_i;
    push_slot.body.rs2 = rs2_i;
    push_slot.id       = id_i;
  end

  matrix_dispatch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (slot_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (handshake & legal),
    .push_data (push_slot),
    .pop       (disp_valid_o & disp_ready_i),
    .head      (head_slot),
    .full      (full),
    .empty     (empty)
  );

  // ---- stage p1: accept/reject response, one cycle after the handshake ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld_p1 <= 1'b0;
      resp_acc_p1 <= 1'b0;
      resp_id_p1  <= '0;
    end else begin
      resp_vld_p1 <= handshake;
      resp_acc_p1 <= handshake & legal;
      resp_id_p1  <= handshake ? id_i : '0;
    end
  end

  assign resp_valid_o  = resp_vld_p1;
  assign resp_accept_o = resp_acc_p1;
  assign resp_id_o     = resp_id_p1;
  assign disp_valid_o  = ~empty;

  // Head presentation; zeroed while empty so stale storage never leaks out
  always_comb begin
    disp_op_o  = OP_NONE;
    disp_md_o  = '0;
    disp_ms1_o = '0;
    disp_ms2_o = '0;
    disp_rs1_o = '0;
    disp_rs2_o = '0;
    disp_id_o  = '0;
    if (!empty) begin
      disp_op_o  = head_slot.body.op;
      disp_md_o  = head_slot.body.md;
      disp_ms1_o = head_slot.body.ms1;
      disp_ms2_o = head_slot.body.ms2;
      disp_rs1_o = head_slot.body.rs1;
      disp_rs2_o = head_slot.body.rs2;
      disp_id_o  = head_slot.id;
    end
  end

endmodule
